// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared FSM state type and scan-code prefix constants for the
//               PS/2 receiver.
// Revision    : 1.0
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  // Odd parity: the eight data bits plus the parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Synchronises ps2_clk/ps2_dat and flags falling ps2_clk edges,
//               with the data sample aligned to the edge strobe.
// Revision    : 1.0
// ============================================================================
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic clk_fall,
  output logic dat_s
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;

  // Clearing to 0 means a line already high after reset reads as a rise, never a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      clk_fall <= 1'b0;
      dat_s    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      clk_fall <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      dat_s    <= dat_sync[SYNC_STAGES-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_receiver
// Description : PS/2 device-to-host frame receiver with E0/F0 prefix decoder.
//               Optional macro PS2_PARITY_CHECK_EN enables parity rejection.
// Revision    : 1.0
// ============================================================================
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err
);

  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_fall;
  logic          dat_s;
  ps2_state_t    state;
  ps2_state_t    state_next;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] timer;
  logic          timeout_hit;
  logic          parity_ok;
  logic          frame_ok;
  logic          frame_bad;
  logic          ext_pend;
  logic          brk_pend;

  ps2_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk      (CLOCK_50),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .clk_fall (clk_fall),
    .dat_s    (dat_s)
  );

  assign timeout_hit = (state != IDLE) && (timer == TIMEOUT_LAST);

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (clk_fall && state == PARITY) begin
      parity_bit <= dat_s;
    end
  end

  assign parity_ok = odd_parity_ok(shreg, parity_bit);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An edge in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_next = state;
    if (clk_fall) begin
      case (state)
        IDLE:    state_next = dat_s ? IDLE : DATA;
        DATA:    state_next = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (clk_fall) begin
      if (state == IDLE && dat_s) begin
        frame_bad = 1'b1;
      end else if (state == STOP) begin
        frame_ok  = dat_s & parity_ok;
        frame_bad = ~(dat_s & parity_ok);
      end
    end else if (timeout_hit) begin
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      timer      <= '0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= frame_ok;
      frame_err  <= frame_bad;
      if (frame_ok) begin
        byte_data <= shreg;
      end

      if (clk_fall || state == IDLE) begin
        timer <= '0;
      end else begin
        timer <= timer + TW'(1);
      end

      if (clk_fall) begin
        if (state == IDLE) begin
          bit_cnt <= 3'd0;
          shreg   <= 8'h00;
        end else if (state == DATA) begin
          shreg   <= {dat_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (timeout_hit) begin
        bit_cnt <= 3'd0;
        shreg   <= 8'h00;
      end
    end
  end

  // Prefix bytes only arm flags; the next ordinary byte carries them out.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      code        <= 8'h00;
      code_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      if (byte_valid) begin
        if (byte_data == PS2_EXT_PREFIX) begin
          ext_pend <= 1'b1;
        end else if (byte_data == PS2_BREAK_PREFIX) begin
          brk_pend <= 1'b1;
        end else begin
          code        <= byte_data;
          is_break    <= brk_pend;
          is_extended <= ext_pend;
          code_valid  <= 1'b1;
          ext_pend    <= 1'b0;
          brk_pend    <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scan_receiver
// Description : Self-checking bench: directed frame table, corner sequences
//               and randomized frames against a scan-code reference model.
// Revision    : 1.0
// ============================================================================
module tb_ps2_scan_receiver;

  localparam int T    = 200;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_scan_receiver #(
    .TIMEOUT_CYCLES (T),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .code        (code),
    .code_valid  (code_valid),
    .is_break    (is_break),
    .is_extended (is_extended),
    .frame_err   (frame_err)
  );

  // Pulse monitor: running totals plus the payload and cycle of the latest pulse.
  int         bv_cnt = 0, cv_cnt = 0, err_cnt = 0;
  int         bv_cyc = 0, cv_cyc = 0, err_cyc = 0;
  logic [7:0] bv_byte = 8'h00, cv_code = 8'h00;
  logic       cv_brk = 1'b0, cv_ext = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) begin bv_cnt++; bv_byte = byte_data; bv_cyc = cyc; end
    if (code_valid) begin cv_cnt++; cv_code = code; cv_brk = is_break; cv_ext = is_extended; cv_cyc = cyc; end
    if (frame_err) begin err_cnt++; err_cyc = cyc; end
  end

  int half = 8;
  int last_edge = 0;
  int s_bv, s_cv, s_err;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_bv = bv_cnt; s_cv = cv_cnt; s_err = err_cnt;
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(half);
    ps2_clk = 1'b0;
    last_edge = cyc;
    tick(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    logic p;
    p = ~(^d) ^ pflip;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    ps2_dat = 1'b1;
    tick(8);
  endtask

  task automatic check_frame(input string tag, input logic ebv, input logic [7:0] eb,
                             input logic eerr, input logic ecv, input logic [7:0] ec,
                             input logic ebrk, input logic eext);
    check({tag, " byte_valid count"}, bv_cnt - s_bv, int'(ebv));
    check({tag, " frame_err count"}, err_cnt - s_err, int'(eerr));
    check({tag, " code_valid count"}, cv_cnt - s_cv, int'(ecv));
    if (ebv) begin
      check({tag, " byte_data"}, bv_byte, eb);
      check({tag, " byte_valid latency"}, bv_cyc - last_edge, LAT);
    end
    if (eerr) check({tag, " frame_err latency"}, err_cyc - last_edge, LAT);
    if (ecv) begin
      check({tag, " code"}, cv_code, ec);
      check({tag, " is_break"}, cv_brk, ebrk);
      check({tag, " is_extended"}, cv_ext, eext);
      check({tag, " code_valid after byte_valid"}, cv_cyc - bv_cyc, 1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " byte_data"}, byte_data, 0);
    check({tag, " byte_valid"}, byte_valid, 0);
    check({tag, " code"}, code, 0);
    check({tag, " code_valid"}, code_valid, 0);
    check({tag, " is_break"}, is_break, 0);
    check({tag, " is_extended"}, is_extended, 0);
    check({tag, " frame_err"}, frame_err, 0);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pflip;
    logic       stop;
    logic       ebv;
    logic       eerr;
    logic       ecv;
    logic [7:0] ec;
    logic       ebrk;
    logic       eext;
  } vec_t;

  vec_t tbl[13];

  initial begin
    //           data   pflip stop  bv    err   cv    code   brk   ext
    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0};
    tbl[1]  = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0};
    tbl[3]  = '{8'hE0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[4]  = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h75, 1'b1, 1'b1};
    tbl[6]  = '{8'h1A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    tbl[7]  = '{8'h1A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
`else
    tbl[7]  = '{8'h1A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0};
`endif
    tbl[8]  = '{8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[9]  = '{8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0};
    tbl[11] = '{8'hE0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[12] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h6B, 1'b0, 1'b1};

    reset = 1'b1;
    tick(5);
    @(negedge clk);
    check_outputs_zero("reset");
    tick(1);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 13; i++) begin
      snap();
      send_frame(tbl[i].d, tbl[i].pflip, tbl[i].stop);
      check_frame($sformatf("table[%0d]", i), tbl[i].ebv, tbl[i].d, tbl[i].eerr,
                  tbl[i].ecv, tbl[i].ec, tbl[i].ebrk, tbl[i].eext);
    end

    // Start bit read as 1 while idle.
    snap();
    send_bit(1'b1);
    ps2_dat = 1'b1;
    tick(8);
    check_frame("bad start", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

    // Frame abandoned after four data bits.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    ps2_dat = 1'b1;
    tick(T + LAT + 10);
    check("timeout frame_err count", err_cnt - s_err, 1);
    check("timeout frame_err latency", err_cyc - last_edge, T + LAT);
    check("timeout byte_valid count", bv_cnt - s_bv, 0);
    snap();
    send_frame(8'h1A, 1'b0, 1'b1);
    check_frame("after timeout", 1'b1, 8'h1A, 1'b0, 1'b1, 8'h1A, 1'b0, 1'b0);

    // Reset mid-frame with a break prefix pending.
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    check_frame("pre-reset F0", 1'b1, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid-frame reset");
    tick(T + 20);
    check("post-reset byte_valid count", bv_cnt - s_bv, 0);
    check("post-reset code_valid count", cv_cnt - s_cv, 0);
    check("post-reset frame_err count", err_cnt - s_err, 0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check_frame("after reset", 1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0);

    // Randomized frames against a scan-code model: prefixes accumulate, a
    // plain byte releases them, rejected frames leave them untouched.
    begin
      logic       m_ext, m_brk;
      logic [7:0] d;
      logic       pflip, stop, good, ebv, eerr, ecv, ebrk, eext;
      logic [7:0] ec;
      int         r;
      m_ext = 1'b0;
      m_brk = 1'b0;
      for (int n = 0; n < 40; n++) begin
        r     = $urandom_range(0, 9);
        d     = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
        pflip = ($urandom_range(0, 7) == 0);
        stop  = ($urandom_range(0, 11) != 0);
        half  = $urandom_range(4, 10);
        good  = stop && !(PCHK && pflip);
        ebv = good; eerr = !good; ecv = 1'b0; ec = 8'h00; ebrk = 1'b0; eext = 1'b0;
        if (good) begin
          if (d == 8'hE0) m_ext = 1'b1;
          else if (d == 8'hF0) m_brk = 1'b1;
          else begin
            ecv = 1'b1; ec = d; ebrk = m_brk; eext = m_ext;
            m_ext = 1'b0; m_brk = 1'b0;
          end
        end
        snap();
        send_frame(d, pflip, stop);
        check_frame($sformatf("random[%0d] d=%0h", n, d), ebv, d, eerr, ecv, ec, ebrk, eext);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Host-side PS/2 receiver that sits directly downstream of the PS/2 keyboard model, consuming its `ps2_clk`/`ps2_dat` lines. Oversamples the bus with the system clock, deserialises 11-bit device-to-host frames, checks framing, and emits raw bytes. A decode stage folds `E0` (extended) and `F0` (break) prefixes into flags on a single key-code event for downstream display/LED logic.

## Interface
- `TIMEOUT_CYCLES`, 50000: system clocks without a falling `ps2_clk` edge before an in-progress frame is abandoned (1 ms at 50 MHz).
- `SYNC_STAGES`, 2: synchroniser depth on `ps2_clk` and `ps2_dat`; legal range 2–3.

Ports:
- `CLOCK_50`  in  1  system clock. One clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  PS/2 clock from keyboard, asynchronous.
- `ps2_dat`  in  1  PS/2 data from keyboard, asynchronous.
- `byte_data`  out  8  last received raw byte.
- `byte_valid`  out  1  one-cycle pulse; `byte_data` is valid.
- `code`  out  8  decoded key code (prefixes stripped).
- `code_valid`  out  1  one-cycle pulse; `code`, `is_break`, `is_extended` are valid.
- `is_break`  out  1  code was preceded by `F0`.
- `is_extended`  out  1  code was preceded by `E0`.
- `frame_err`  out  1  one-cycle pulse on bad start, stop, parity, or timeout.

## Operation
- Both inputs pass through `SYNC_STAGES` flops.
- A falling edge is the synced `ps2_clk` going from 1 to 0. Synced `ps2_dat` is sampled in the same cycle.
- Frame format: start(0), d0..d7 LSB first, odd parity, stop(1).
- FSM states:
  - IDLE: on an edge, if data is 0 go to DATA with bit count 0; if data is 1, pulse `frame_err` and stay in IDLE.
  - DATA: on each edge shift data in; after the 8th bit go to PARITY.
  - PARITY: on an edge latch the parity bit; go to STOP.
  - STOP: on an edge, if stop bit is 1 and parity is good, pulse `byte_valid`; otherwise pulse `frame_err`. Go to IDLE either way.
- Timeout counter:
  - Clears on every edge and in IDLE; increments otherwise.
  - On reaching `TIMEOUT_CYCLES`, go to IDLE, pulse `frame_err`, discard partial data.
- Decoder (runs on `byte_valid`):
  - `E0`: set pending-extended; no `code_valid`.
  - `F0`: set pending-break; no `code_valid`.
  - Any other byte: pulse `code_valid` with the flags, then clear both flags.
  - Flags are not cleared by `frame_err`.
- Reset values: all outputs 0; FSM in IDLE; counters, flags and shift register cleared.
- Reset mid-frame discards the frame. The next frame is received normally.
- An edge and timeout expiry in the same cycle: the edge wins.

## Timing
- Edge detection lags the pin by `SYNC_STAGES`+1 cycles.
- `byte_valid` and `frame_err` are asserted the cycle after the stop-bit edge is detected.
- `code_valid` is asserted the cycle after `byte_valid`.
- `byte_data` holds its value until the next `byte_valid`. `code`, `is_break` and `is_extended` hold until the next `code_valid`.
- Minimum supported `ps2_clk` half-period: 4 system cycles.

## Configuration
- `PS2_PARITY_CHECK_EN`:
  - Defined: a parity mismatch drops the byte and pulses `frame_err`.
  - Undefined: the parity bit is shifted and ignored; only start, stop and timeout produce `frame_err`.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants `PS2_EXT_PREFIX`=8'hE0 and `PS2_BREAK_PREFIX`=8'hF0.
- Sub-module `ps2_line_sync`: synchroniser plus falling-edge detector. Outputs `clk_fall` and `dat_s`.
- The FSM and decoder live in the top module.

## Test plan
- Frame 0x1C (parity bit 0), start 0, stop 1 -> `byte_valid` with `byte_data`=0x1C; next cycle `code_valid`, `code`=0x1C, `is_break`=0, `is_extended`=0.
- Frames F0 then 1C -> `byte_valid` twice; exactly one `code_valid` with `code`=0x1C, `is_break`=1.
- Frames E0, F0, 75 -> one `code_valid`: `code`=0x75, `is_extended`=1, `is_break`=1. Following frame 1A -> both flags 0.
- Frame 0x1A with parity bit forced wrong:
  - with `PS2_PARITY_CHECK_EN` -> `frame_err` pulse, no `byte_valid`;
  - without it -> `byte_valid`, `byte_data`=0x1A.
- Start + 4 data bits, then `ps2_clk` held high -> exactly `TIMEOUT_CYCLES` after the last edge `frame_err` pulses; following frame 0x1A is received correctly.
- `reset` asserted for one cycle mid-frame (after bit 3) -> outputs 0, no pulses; subsequent frame 0x1C decodes with flags 0.
